nonoverlap_clkgen_multi: RTL and testbench
==========================================

# nonoverlap_clkgen_multi

Parametrised, counter-based non-overlapping multi-phase clock generator: the next generation of the fixed two-phase shift-register generator. Produces NPH mutually exclusive phase clocks with programmable slot length and dead time, plus a frame-rate MODL clock and frame strobe. Sits between the system clock and the modulator/readout blocks. Slot and dead time are reconfigurable at run time and applied only on frame boundaries.

## Interface

Parameters:
- NPH, 2: number of phases; even, 2..8.
- CW, 8: width of slot and dead-time counters.
- SLOT_INIT, 16: slot length in CLK_IN cycles after reset.
- DEAD_INIT, 4: dead cycles at the start of each slot after reset.

Ports:
- CLK_IN  in  1  sole clock.
- RST_IN  in  1  reset; synchronous, active-high.
- EN  in  1  run request; sampled in IDLE and on the last cycle of each frame.
- CFG_SLOT  in  CW  requested slot length.
- CFG_DEAD  in  CW  requested dead time.
- CFG_VALID  in  1  config offer.
- CFG_READY  out  1  high when the pending-config register is empty.
- CFG_ERR  out  1  one-cycle pulse when an accepted config is rejected.
- CLK_OUT_PH  out  NPH  phase clocks; bit k = phase k.
- CLK_OUT_MODL  out  1  high for the first NPH/2 slots of each frame.
- FRAME_STB  out  1  one-cycle pulse aligned with outputs of frame cycle 0.

## Operation

- Reset: state IDLE, slot=0, cnt=0, active config = (SLOT_INIT, DEAD_INIT), pending empty. All outputs 0 except CFG_READY=1.
- Counters: cnt runs 0..SLOT-1. On wrap, slot advances 0..NPH-1. Frame = NPH*SLOT cycles.
- States:
  - IDLE: counters held at (0,0), outputs 0. Moves to RUN when EN=1.
  - RUN: counters advance each cycle. On the frame-end cycle (slot=NPH-1, cnt=SLOT-1): load pending config if present; go to IDLE if EN=0, otherwise wrap to (0,0).
- EN dropping mid-frame: the frame completes; phases are never truncated.
- Decode, registered:
  - CLK_OUT_PH[k] = RUN && slot==k && cnt>=DEAD.
  - CLK_OUT_MODL = RUN && slot<NPH/2.
  - FRAME_STB = RUN && slot==0 && cnt==0.
- Non-overlap: at most one phase bit high in any cycle, for every legal config. DEAD=0 gives adjacent phases back-to-back with no gap.
- Config handshake:
  - Transfer occurs when CFG_VALID && CFG_READY. Data goes to the pending register; CFG_READY falls the next cycle.
  - Legal config: 2 <= CFG_SLOT and CFG_DEAD < CFG_SLOT.
  - Illegal config: accepted but discarded; CFG_ERR pulses the cycle after transfer; CFG_READY stays 1.
  - Pending config applies on the next frame end, or on the next cycle if IDLE. CFG_READY returns high the cycle after application.
  - Transfer on the frame-end cycle with pending empty: applies at the following frame end.
- RST_IN mid-frame: next cycle is the reset state; outputs forced 0 immediately after that edge; pending config lost.

## Timing

- Output latency: 1 cycle from counter state to pins. The first RUN cycle shows IDLE outputs; the second shows decode of (0,0).
- EN=1 sampled in IDLE: FRAME_STB at cycle +2.
- Phase k high time: SLOT-DEAD cycles. Gap between phases: DEAD cycles.
- All outputs are flop-driven; no combinational path from inputs to outputs.

## Configuration

- NOVL_CLKGEN_GUARD_EN defined: adds an overlap guard.
  - If the registered phase vector has more than one bit set, all phases are forced to 0 from the next cycle.
  - A sticky FAULT output (1 bit, reset 0) is set; cleared only by RST_IN.
- Undefined: no guard logic and no FAULT port; phases are driven directly from the decode.

## Test plan

- Defaults, NPH=2, EN=1 held: PH[0] high 12 cycles, low 20; PH[1] same, shifted 16; MODL 16 high/16 low; FRAME_STB every 32 cycles.
- NPH=4, config (SLOT=5, DEAD=1) offered mid-frame: current frame unchanged; from the next frame each phase is high 4 of every 20 cycles; CFG_READY low until application.
- Config (SLOT=3, DEAD=3) -> CFG_ERR one pulse; timing unchanged; CFG_READY stays 1.
- EN deasserted at slot 0 -> frame completes all NPH phases, then outputs stay 0; EN reasserted -> FRAME_STB two cycles later.
- RST_IN asserted mid-phase -> all outputs 0 the cycle after the edge; config returns to SLOT_INIT/DEAD_INIT.
- With NOVL_CLKGEN_GUARD_EN, force two phase bits high -> phases 0 next cycle; FAULT=1 until reset.

Source files
------------

// File: rtl/nonoverlap_clkgen_multi.sv
// rtl/nonoverlap_clkgen_multi.sv - counter-based non-overlapping NPH-phase clock generator
// Optional overlap guard with sticky FAULT output: define NOVL_CLKGEN_GUARD_EN.
module nonoverlap_clkgen_multi #(
    parameter int NPH       = 2,
    parameter int CW        = 8,
    parameter int SLOT_INIT = 16,
    parameter int DEAD_INIT = 4
) (
    input  logic           CLK_IN,
    input  logic           RST_IN,
    input  logic           EN,
    input  logic [CW-1:0]  CFG_SLOT,
    input  logic [CW-1:0]  CFG_DEAD,
    input  logic           CFG_VALID,
    output logic           CFG_READY,
    output logic           CFG_ERR,
    output logic [NPH-1:0] CLK_OUT_PH,
    output logic           CLK_OUT_MODL,
    output logic           FRAME_STB
`ifdef NOVL_CLKGEN_GUARD_EN
    ,
    output logic           FAULT
`endif
);
    localparam int SW = (NPH > 1) ? $clog2(NPH) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t         state;
    logic [SW-1:0]  slot;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  act_slot;
    logic [CW-1:0]  act_dead;
    logic [CW-1:0]  pend_slot;
    logic [CW-1:0]  pend_dead;
    logic           pend_valid;

    logic           xfer;
    logic           cfg_legal;
    logic           slot_end;
    logic           frame_end;
    logic           apply;
    logic           pend_next;
    logic [NPH-1:0] ph_dec;

    always_comb begin
        xfer      = CFG_VALID && CFG_READY;
        cfg_legal = (CFG_SLOT >= CW'(2)) && (CFG_DEAD < CFG_SLOT);
        slot_end  = (cnt == act_slot - CW'(1));
        frame_end = (state == RUN) && slot_end && (slot == SW'(NPH - 1));
        // New timing only ever takes effect between frames (or while idle).
        apply     = pend_valid && ((state == IDLE) || frame_end);
        pend_next = (pend_valid && !apply) || (xfer && cfg_legal);
        ph_dec    = '0;
        for (int k = 0; k < NPH; k++) begin
            ph_dec[k] = (state == RUN) && (slot == SW'(k)) && (cnt >= act_dead);
        end
    end

`ifdef NOVL_CLKGEN_GUARD_EN
    logic multi_hot;
    assign multi_hot = |(CLK_OUT_PH & (CLK_OUT_PH - NPH'(1)));
`endif

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state        <= IDLE;
            slot         <= '0;
            cnt          <= '0;
            act_slot     <= CW'(SLOT_INIT);
            act_dead     <= CW'(DEAD_INIT);
            pend_valid   <= 1'b0;
            pend_slot    <= '0;
            pend_dead    <= '0;
            CFG_READY    <= 1'b1;
            CFG_ERR      <= 1'b0;
            CLK_OUT_PH   <= '0;
            CLK_OUT_MODL <= 1'b0;
            FRAME_STB    <= 1'b0;
`ifdef NOVL_CLKGEN_GUARD_EN
            FAULT        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    slot <= '0;
                    cnt  <= '0;
                    if (EN) state <= RUN;
                end
                RUN: begin
                    if (frame_end) begin
                        slot <= '0;
                        cnt  <= '0;
                        if (!EN) state <= IDLE;
                    end else if (slot_end) begin
                        slot <= slot + SW'(1);
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (apply) begin
                act_slot <= pend_slot;
                act_dead <= pend_dead;
            end
            if (xfer && cfg_legal) begin
                pend_slot <= CFG_SLOT;
                pend_dead <= CFG_DEAD;
            end
            pend_valid <= pend_next;
            CFG_READY  <= !pend_next;
            CFG_ERR    <= xfer && !cfg_legal;

            CLK_OUT_MODL <= (state == RUN) && (slot < SW'(NPH / 2));
            FRAME_STB    <= (state == RUN) && (slot == '0) && (cnt == '0);
`ifdef NOVL_CLKGEN_GUARD_EN
            if (multi_hot) FAULT <= 1'b1;
            CLK_OUT_PH <= (FAULT || multi_hot) ? '0 : ph_dec;
`else
            CLK_OUT_PH <= ph_dec;
`endif
        end
    end
endmodule

// File: tb/tb_nonoverlap_clkgen_multi.sv
// tb/tb_nonoverlap_clkgen_multi.sv - randomized bench with frame-position reference model
module tb_nonoverlap_clkgen_multi;
    localparam int NPH       = 4;
    localparam int CW        = 8;
    localparam int SLOT_INIT = 16;
    localparam int DEAD_INIT = 4;
    localparam int FRAME0    = NPH * SLOT_INIT;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           cfg_valid;
    logic [CW-1:0]  cfg_slot;
    logic [CW-1:0]  cfg_dead;
    logic           cfg_ready;
    logic           cfg_err;
    logic [NPH-1:0] ph;
    logic           modl;
    logic           stb;
`ifdef NOVL_CLKGEN_GUARD_EN
    logic           fault;
`endif

    always #5 clk = ~clk;

    nonoverlap_clkgen_multi #(
        .NPH(NPH), .CW(CW), .SLOT_INIT(SLOT_INIT), .DEAD_INIT(DEAD_INIT)
    ) dut (
        .CLK_IN      (clk),
        .RST_IN      (rst),
        .EN          (en),
        .CFG_SLOT    (cfg_slot),
        .CFG_DEAD    (cfg_dead),
        .CFG_VALID   (cfg_valid),
        .CFG_READY   (cfg_ready),
        .CFG_ERR     (cfg_err),
        .CLK_OUT_PH  (ph),
        .CLK_OUT_MODL(modl),
        .FRAME_STB   (stb)
`ifdef NOVL_CLKGEN_GUARD_EN
        ,
        .FAULT       (fault)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: position within frame instead of slot/cnt counters.
    bit             m_run;
    int             m_pos;
    int             m_len;
    int             m_dead;
    bit             m_pend;
    int             m_plen;
    int             m_pdead;
    logic [NPH+3:0] exp_v;

    function automatic logic [NPH+3:0] obs();
        return {ph, modl, stb, cfg_ready, cfg_err};
    endfunction

    task automatic tick();
        logic [NPH-1:0] e_ph;
        bit e_modl, e_stb, e_err, xfer, legal, last, apply;
        int s, c;
        if (rst) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_len  = SLOT_INIT;
            m_dead = DEAD_INIT;
            m_pend = 1'b0;
            exp_v  = {{NPH{1'b0}}, 4'b0010};
        end else begin
            s    = m_pos / m_len;
            c    = m_pos % m_len;
            e_ph = '0;
            if (m_run && c >= m_dead) e_ph[s] = 1'b1;
            e_modl = m_run && (s < NPH / 2);
            e_stb  = m_run && (m_pos == 0);
            xfer   = cfg_valid && !m_pend;
            legal  = (int'(cfg_slot) >= 2) && (cfg_dead < cfg_slot);
            e_err  = xfer && !legal;
            last   = m_run && (m_pos == NPH * m_len - 1);
            apply  = m_pend && (!m_run || last);
            if (!m_run) begin
                m_run = en;
                m_pos = 0;
            end else if (last) begin
                m_run = en;
                m_pos = 0;
            end else begin
                m_pos++;
            end
            if (apply) begin
                m_len  = m_plen;
                m_dead = m_pdead;
                m_pend = 1'b0;
            end
            if (xfer && legal) begin
                m_pend  = 1'b1;
                m_plen  = int'(cfg_slot);
                m_pdead = int'(cfg_dead);
            end
            exp_v = {e_ph, e_modl, e_stb, !m_pend, e_err};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_slot = '0; cfg_dead = '0;
        tick();
        tick();
        vectors++;
        if (obs() !== {{NPH{1'b0}}, 4'b0010}) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected %b", obs(), {{NPH{1'b0}}, 4'b0010});
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (obs() !== exp_v) begin
                miscompares++;
                $display("FAIL reset_idle: got %b expected %b", obs(), exp_v);
            end
        end
    endtask

    task automatic test_defaults();
        int n_ph0, n_stb, n_modl;
        n_ph0 = 0; n_stb = 0; n_modl = 0;
        en = 1'b1;
        for (int i = 0; i < 2 * FRAME0 + 2; i++) begin
            tick();
            vectors++;
            if (obs() !== exp_v) begin
                miscompares++;
                $display("FAIL defaults_cycle %0d: got %b expected %b", i, obs(), exp_v);
            end
            if (i >= 1 && i < 2 * FRAME0 + 1) begin
                n_ph0  += int'(ph[0]);
                n_stb  += int'(stb);
                n_modl += int'(modl);
            end
        end
        vectors++;
        if (n_ph0 != 2 * (SLOT_INIT - DEAD_INIT) || n_stb != 2 || n_modl != FRAME0) begin
            miscompares++;
            $display("FAIL defaults_counts: ph0=%0d stb=%0d modl=%0d expected %0d 2 %0d",
                     n_ph0, n_stb, n_modl, 2 * (SLOT_INIT - DEAD_INIT), FRAME0);
        end
    endtask

    task automatic test_cfg_midframe();
        int n_hi [NPH];
        for (int i = 0; i < 7; i++) begin
            tick();
            vectors++;
            if (obs() !== exp_v) begin
                miscompares++;
                $display("FAIL cfg_pre: got %b expected %b", obs(), exp_v);
            end
        end
        cfg_valid = 1'b1; cfg_slot = 8'd5; cfg_dead = 8'd1;
        tick();
        cfg_valid = 1'b0;
        vectors++;
        if (cfg_ready !== 1'b0 || obs() !== exp_v) begin
            miscompares++;
            $display("FAIL cfg_accept: ready=%b got %b expected ready=0 %b", cfg_ready, obs(), exp_v);
        end
        for (int i = 0; i < FRAME0 + 40; i++) begin
            tick();
            vectors++;
            if (obs() !== exp_v) begin
                miscompares++;
                $display("FAIL cfg_cycle %0d: got %b expected %b", i, obs(), exp_v);
            end
        end
        for (int k = 0; k < NPH; k++) n_hi[k] = 0;
        for (int i = 0; i < NPH * 5; i++) begin
            tick();
            for (int k = 0; k < NPH; k++) n_hi[k] += int'(ph[k]);
        end
        for (int k = 0; k < NPH; k++) begin
            vectors++;
            if (n_hi[k] != 4) begin
                miscompares++;
                $display("FAIL cfg_new_high ph%0d: got %0d expected 4", k, n_hi[k]);
            end
        end
    endtask

    task automatic test_illegal();
        int n_hi;
        n_hi = 0;
        cfg_valid = 1'b1; cfg_slot = 8'd3; cfg_dead = 8'd3;
        tick();
        cfg_valid = 1'b0;
        vectors++;
        if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || obs() !== exp_v) begin
            miscompares++;
            $display("FAIL illegal_pulse: err=%b ready=%b got %b expected err=1 ready=1 %b",
                     cfg_err, cfg_ready, obs(), exp_v);
        end
        tick();
        vectors++;
        if (cfg_err !== 1'b0 || obs() !== exp_v) begin
            miscompares++;
            $display("FAIL illegal_single: err=%b got %b expected err=0 %b", cfg_err, obs(), exp_v);
        end
        for (int i = 0; i < NPH * 5; i++) begin
            tick();
            n_hi += int'(ph[2]);
            vectors++;
            if (obs() !== exp_v) begin
                miscompares++;
                $display("FAIL illegal_cycle %0d: got %b expected %b", i, obs(), exp_v);
            end
        end
        vectors++;
        if (n_hi != 4) begin
            miscompares++;
            $display("FAIL illegal_timing: ph2 high %0d expected 4", n_hi);
        end
    endtask

    task automatic test_en_drop();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            found = (stb === 1'b1);
            vectors++;
            if (obs() !== exp_v) begin
                miscompares++;
                $display("FAIL endrop_wait: got %b expected %b", obs(), exp_v);
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL endrop_stb_timeout: got none expected FRAME_STB");
        end
        en = 1'b0;
        for (int i = 0; i < NPH * 5 + 6; i++) begin
            tick();
            vectors++;
            if (obs() !== exp_v) begin
                miscompares++;
                $display("FAIL endrop_cycle %0d: got %b expected %b", i, obs(), exp_v);
            end
        end
        vectors++;
        if ({ph, modl, stb} !== '0) begin
            miscompares++;
            $display("FAIL endrop_idle: got %b expected 0", {ph, modl, stb});
        end
        en = 1'b1;
        tick();
        vectors++;
        if (stb !== 1'b0 || obs() !== exp_v) begin
            miscompares++;
            $display("FAIL restart_plus1: got %b expected %b", obs(), exp_v);
        end
        tick();
        vectors++;
        if (stb !== 1'b1 || obs() !== exp_v) begin
            miscompares++;
            $display("FAIL restart_plus2: stb=%b got %b expected stb=1 %b", stb, obs(), exp_v);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int n_ph0;
        found = 1'b0; n_ph0 = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            found = (ph[1] === 1'b1);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL rstmid_wait_timeout: got none expected ph1 high");
        end
        cfg_valid = 1'b1; cfg_slot = 8'd7; cfg_dead = 8'd2;
        tick();
        cfg_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (obs() !== {{NPH{1'b0}}, 4'b0010}) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got %b expected %b", obs(), {{NPH{1'b0}}, 4'b0010});
        end
        for (int i = 0; i < FRAME0 + 2; i++) begin
            tick();
            if (i >= 1 && i < FRAME0 + 1) n_ph0 += int'(ph[0]);
            vectors++;
            if (obs() !== exp_v) begin
                miscompares++;
                $display("FAIL rstmid_cycle %0d: got %b expected %b", i, obs(), exp_v);
            end
        end
        vectors++;
        if (n_ph0 != SLOT_INIT - DEAD_INIT) begin
            miscompares++;
            $display("FAIL rstmid_cfg_restored: ph0 high %0d expected %0d", n_ph0, SLOT_INIT - DEAD_INIT);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            en        = ($urandom_range(0, 7) != 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_slot  = CW'($urandom_range(0, 9));
            cfg_dead  = CW'($urandom_range(0, 9));
            tick();
            vectors++;
            if (obs() !== exp_v) begin
                miscompares++;
                $display("FAIL random_cycle %0d: got %b expected %b", i, obs(), exp_v);
            end
            vectors++;
            if ($countones(ph) > 1) begin
                miscompares++;
                $display("FAIL random_overlap %0d: got %b expected at most one bit", i, ph);
            end
        end
        rst = 1'b0; cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_cfg_midframe();
        test_illegal();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
